shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (power of 2, 8..64).
REQ-002 SHALL have parameter AMT_W, default 5, shift-amount width; WIDTH == 2**AMT_W.
REQ-003 SHALL have parameter STEP, default 1, maximum bits shifted per cycle (power of 2, 1..WIDTH/2).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port in_data  input  WIDTH  operand.
REQ-009 SHALL have port in_amt  input  AMT_W  shift amount, 0..WIDTH-1.
REQ-010 SHALL have port in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (see REQ-030).
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_data  output  WIDTH  result, registered.
REQ-014 SHALL have port busy  output  1  high in SHIFT or HOLD.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, HOLD; in_ready = (state == IDLE); out_valid = (state == HOLD); busy = (state != IDLE).
REQ-016 Acceptance SHALL occur on a rising edge with in_valid & in_ready; data, amount and mode are latched then; inputs are ignored at all other times.
REQ-017 On acceptance with in_amt == 0 the FSM SHALL go to HOLD with out_data = in_data.
REQ-018 On acceptance with in_amt != 0 the FSM SHALL go to SHIFT with remaining = in_amt.
REQ-019 Each SHIFT edge SHALL shift the working register by min(STEP, remaining) and decrement remaining by that amount; when remaining reaches 0 the FSM goes to HOLD on the same edge.
REQ-020 out_valid SHALL rise after exactly ceil(amt/STEP)+1 rising edges, counting the accepting edge.
REQ-021 SLL SHALL fill with 0 from the LSB; SRL SHALL fill with 0 from the MSB; SRA SHALL fill with bit WIDTH-1 of the latched operand.
REQ-022 In HOLD, out_data SHALL be stable until the edge where out_ready == 1; that edge returns the FSM to IDLE.
REQ-023 out_ready while not in HOLD SHALL have no effect; in_valid while not in IDLE SHALL not be accepted or queued.
REQ-024 Final result SHALL equal the single-step shift of the operand by amt for every STEP value.

Reset
REQ-025 rst_n low SHALL immediately, without a clock edge, force state IDLE, out_data 0, remaining 0, working register 0.
REQ-026 Outputs during reset SHALL be in_ready 1, out_valid 0, busy 0, out_data 0.
REQ-027 Reset asserted in SHIFT or HOLD SHALL abort the operation; no result is produced after release.
REQ-028 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro SHIFT_SEQ_ROTATE_EN SHALL control rotate support.
REQ-030 With SHIFT_SEQ_ROTATE_EN defined, mode 11 SHALL rotate left (MSBs wrap into LSBs) with the same latency as other modes.
REQ-031 Without SHIFT_SEQ_ROTATE_EN, mode 11 SHALL behave exactly as SLL and no rotate logic SHALL be present.

Verification
REQ-032 WIDTH 32, STEP 1: in_data 0x0000_0001, amt 2, SLL, out_ready 1 -> out_valid after 3 edges, out_data 0x0000_0004 (branch-offset shift case).
REQ-033 STEP 4: in_data 0x8000_0000, amt 31, SRA -> out_valid after 9 edges, out_data 0xFFFF_FFFF.
REQ-034 amt 0, SRL, in_data 0xDEAD_BEEF -> out_valid after 1 edge, out_data 0xDEAD_BEEF; out_ready held 0 for 5 cycles -> out_data stable, in_ready 0 throughout.
REQ-035 rst_n pulsed low mid-SHIFT (amt 20, STEP 1, cycle 5) -> out_valid 0, in_ready 1, out_data 0 immediately; no result after release.
REQ-036 ROTATE_EN defined: in_data 0x8000_0001, amt 1, mode 11 -> 0x0000_0003; undefined: same stimulus -> 0x0000_0002.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle barrel-less shifter. Shifts an operand by up to
// STEP bits per clock until the requested amount is consumed. The result is
// then held until the consumer accepts it.
// Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
// Define SHIFT_SEQ_ROTATE_EN to enable rotate-left in mode 11. Without it,
// mode 11 behaves as SLL and no rotate logic is built.
module shift_seq #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [AMT_W-1:0]   remaining;
    logic [1:0]         mode;
    logic               sign;
    logic [AMT_W-1:0]   step_n;
    logic [WIDTH-1:0]   shifted;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    // Per-cycle partial shift: move by min(STEP, remaining) in the latched mode
    always_comb begin
        step_n  = (remaining > STEP_A) ? STEP_A : remaining;
        shifted = work << step_n;
        case (mode)
            2'b01: shifted = work >> step_n;
            // Fill comes from the latched operand MSB, not the moving register
            2'b10: shifted = WIDTH'($signed({sign, work}) >>> step_n);
`ifdef SHIFT_SEQ_ROTATE_EN
            // WIDTH == 2**AMT_W, so (0 - step_n) in AMT_W bits is WIDTH - step_n;
            // step_n is never 0 while shifting
            2'b11: shifted = (work << step_n) | (work >> (AMT_W'(0) - step_n));
`endif
            default: shifted = work << step_n;
        endcase
    end

    // Control FSM: accept in IDLE, iterate in SHIFT, present result in HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            remaining <= '0;
            mode      <= 2'b00;
            sign      <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= in_data;
                        mode <= in_mode;
                        sign <= in_data[WIDTH-1];
                        if (in_amt == '0) begin
                            out_data <= in_data;
                            state    <= HOLD;
                        end else begin
                            remaining <= in_amt;
                            state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work      <= shifted;
                    remaining <= remaining - step_n;
                    if (remaining == step_n) begin
                        out_data <= shifted;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed table-driven bench. Two instances (STEP 1 and
// STEP 4) share stimulus so both latency rules and the common result are
// checked on every vector. Multi-cycle corner cases (hold, reset abort,
// first acceptance after reset) are hand-written sequences.
module tb_shift_seq;

    logic        clk, rst_n;
    logic        in_valid, out_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic [1:0]  in_mode;
    logic        in_ready1, out_valid1, busy1;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] out_data1, out_data4;

    int checks = 0;
    int errors = 0;

    shift_seq #(.WIDTH(32), .AMT_W(5), .STEP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .busy(busy1));

    shift_seq #(.WIDTH(32), .AMT_W(5), .STEP(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .busy(busy4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  amt;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one vector to both DUTs; record latency and result of each
    task automatic run_vec(input int idx);
        int lat1, lat4;
        logic [31:0] d1, d4;
        lat1 = 0; lat4 = 0; d1 = '0; d4 = '0;
        @(negedge clk);
        in_data = vecs[idx].data; in_amt = vecs[idx].amt; in_mode = vecs[idx].mode;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid1 && lat1 == 0) begin lat1 = n; d1 = out_data1; end
            if (out_valid4 && lat4 == 0) begin lat4 = n; d4 = out_data4; end
            if (lat1 != 0 && lat4 != 0) break;
        end
        chk($sformatf("v%0d lat step1", idx), lat1, 32'(vecs[idx].amt) + 1);
        chk($sformatf("v%0d lat step4", idx), lat4, (32'(vecs[idx].amt) + 3) / 4 + 1);
        chk($sformatf("v%0d data step1", idx), d1, vecs[idx].exp);
        chk($sformatf("v%0d data step4", idx), d4, vecs[idx].exp);
        @(posedge clk); // let the slower instance leave HOLD
    endtask

    initial begin
        int seen;
        logic [31:0] rot1, rot3, rot8;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot1 = 32'h0000_0003; rot3 = 32'h0000_000C; rot8 = 32'h3456_7812;
`else
        rot1 = 32'h0000_0002; rot3 = 32'h0000_0008; rot8 = 32'h3456_7800;
`endif
        vecs[0]  = '{32'h0000_0001, 5'd2,  2'b00, 32'h0000_0004};
        vecs[1]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
        vecs[2]  = '{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF};
        vecs[3]  = '{32'hF0F0_F0F0, 5'd4,  2'b01, 32'h0F0F_0F0F};
        vecs[4]  = '{32'h7FFF_FFFF, 5'd5,  2'b10, 32'h03FF_FFFF};
        vecs[5]  = '{32'h8000_0001, 5'd1,  2'b11, rot1};
        vecs[6]  = '{32'h1234_5678, 5'd8,  2'b11, rot8};
        vecs[7]  = '{32'hA5A5_A5A5, 5'd31, 2'b00, 32'h8000_0000};
        vecs[8]  = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
        vecs[9]  = '{32'hC000_0000, 5'd7,  2'b10, 32'hFF80_0000};
        vecs[10] = '{32'h8000_0001, 5'd3,  2'b11, rot3};
        vecs[11] = '{32'h0000_00FF, 5'd6,  2'b00, 32'h0000_3FC0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_amt = '0; in_mode = 2'b00;
        #1;
        chk("reset in_ready",  32'(in_ready1),  32'd1);
        chk("reset out_valid", 32'(out_valid1), 32'd0);
        chk("reset busy",      32'(busy1),      32'd0);
        chk("reset out_data",  out_data1,       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i);

        // Hold: result stable with out_ready low, new requests ignored
        @(negedge clk);
        in_data = 32'hDEAD_BEEF; in_amt = 5'd0; in_mode = 2'b01;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 32'h1111_1111; in_amt = 5'd3;
        chk("hold out_valid", 32'(out_valid1 & out_valid4), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold c%0d data1", c), out_data1, 32'hDEAD_BEEF);
            chk($sformatf("hold c%0d data4", c), out_data4, 32'hDEAD_BEEF);
            chk($sformatf("hold c%0d in_ready", c), 32'(in_ready1 | in_ready4), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold release in_ready", 32'(in_ready1 & in_ready4), 32'd1);
        chk("hold release out_valid", 32'(out_valid1 | out_valid4), 32'd0);

        // Reset mid-shift aborts the operation asynchronously
        @(negedge clk);
        in_data = 32'h0000_0001; in_amt = 5'd20; in_mode = 2'b00; in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1; in_valid = 1'b0;
        chk("pre-abort busy", 32'(busy1 & busy4), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(out_valid1 | out_valid4), 32'd0);
        chk("abort in_ready",  32'(in_ready1 & in_ready4), 32'd1);
        chk("abort out_data1", out_data1, 32'd0);
        chk("abort out_data4", out_data4, 32'd0);
        chk("abort busy",      32'(busy1 | busy4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (out_valid1 || out_valid4) seen = 1;
        end
        chk("no result after abort", 32'(seen), 32'd0);

        // First acceptance on the first edge after reset release
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_data = 32'h0000_0001; in_amt = 5'd2; in_mode = 2'b00;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("first edge accept", 32'(busy1), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("first accept valid", 32'(out_valid1), 32'd1);
        chk("first accept data",  out_data1, 32'h0000_0004);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
